branch_resolver: RTL and testbench
==================================

# branch_resolver

Execute-stage companion to the 2-bit branch predictor: it queues every prediction issued at fetch, checks each against the real outcome when the branch resolves in execute, and produces the predictor's `mispredicted`/`update_en` training pulse. On a misprediction it also drives a one-cycle pipeline flush and the correct redirect PC. In-order, one branch resolved per cycle, one fetched per cycle.

## Interface
- `XLEN`, 32, address width.
- `DEPTH`, 4, max in-flight predicted branches (power of 2, ≥2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_br_valid`  in  1  a branch is fetched this cycle; push an entry.
- `fetch_pc`  in  XLEN  PC of the fetched branch.
- `prediction`  in  1  predictor output sampled with the push (1 = taken).
- `ex_br_valid`  in  1  oldest in-flight branch resolves this cycle.
- `ex_taken`  in  1  actual direction.
- `ex_target`  in  XLEN  actual taken target.
- `update_en`  out  1  one-cycle training pulse to the predictor.
- `mispredicted`  out  1  qualified by `update_en`.
- `flush`  out  1  one-cycle pipeline flush.
- `redirect_pc`  out  XLEN  correct next PC, valid when `flush`=1.
- `stall_fetch`  out  1  queue full; fetch must hold.
- `q_count`  out  $clog2(DEPTH)+1  entries in flight.
- `err_underflow`  out  1  sticky: resolve seen with empty queue.

## Operation
- Queue: circular FIFO of `{pred, pc}`; write/read pointers `$clog2(DEPTH)` bits, wrap modulo DEPTH; separate count register.
- Push: `fetch_br_valid` & (not full or pop this cycle) & no mispredict this cycle → write `{prediction, fetch_pc}` at wptr.
- Resolve: `ex_br_valid` & count>0 → pop head; `mis = head.pred ^ ex_taken`.
- Registered outputs on resolve: `update_en`=1, `mispredicted`=mis, `flush`=mis, `redirect_pc` = `ex_taken ? ex_target : head.pc + 4` (modulo 2^XLEN), loaded only when mis.
- Mispredict: all queued entries are wrong-path; at the same edge count←0, rptr←wptr; any same-cycle push is dropped.
- Pop without mispredict plus push: count unchanged, both pointers advance.
- Push while full with no pop: dropped; the source must honour `stall_fetch`. Because the push is dropped, no state changes.
- Resolve with empty queue: ignored (no `update_en`), `err_underflow`←1 until reset.
- `stall_fetch` = (count==DEPTH); combinational from count, does not depend on `ex_br_valid`.
- `q_count` = count register.

## Timing
- Reset (async assert, sync-safe deassert via flops): count=0, pointers=0, `update_en`=`mispredicted`=`flush`=0, `redirect_pc`=0, `err_underflow`=0, `stall_fetch`=0.
- Reset mid-operation discards all entries immediately; no pulse is emitted.
- Resolve latency: outputs appear the cycle after `ex_br_valid` and last exactly one cycle unless another resolve follows back-to-back.
- Push visible in `q_count` the next cycle; a pushed entry may be resolved from the following cycle onward.
- Simultaneous push+mispredict-pop: after the edge count=0 (push lost by design, it was wrong-path).

## Test plan
- Reset, push pc=0x100 pred=0, resolve ex_taken=1 ex_target=0x200 → next cycle update_en=1, mispredicted=1, flush=1, redirect_pc=0x200, q_count=0.
- Push pc=0x40 pred=1, resolve ex_taken=0 → redirect_pc=0x44, flush=1; push pred=1, resolve taken=1 → update_en=1, mispredicted=0, flush=0.
- Push 4 branches with no resolve → q_count=4, stall_fetch=1; 5th push dropped; push+correct resolve same cycle at full → q_count stays 4, FIFO order preserved (heads pc 0x0,0x4,0x8,0xC pop in order).
- Push 3 (pred 0,0,0), resolve first with ex_taken=1 while pushing a 4th → q_count=0 next cycle, later resolve gives err_underflow=1, no update_en.
- Pointer wrap: 10 push/correct-resolve pairs with DEPTH=4 → every update_en pulse has mispredicted=0, q_count never exceeds 1.
- Assert rst_n=0 with 2 entries queued and a resolve pending → all outputs 0 immediately, q_count=0 after release.

Source files
------------

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: queues fetch-time predictions, checks them at
// resolve, emits predictor training pulses and mispredict flush/redirect.
module branch_resolver #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_br_valid,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic                     prediction,
    input  logic                     ex_br_valid,
    input  logic                     ex_taken,
    input  logic [XLEN-1:0]          ex_target,
    output logic                     update_en,
    output logic                     mispredicted,
    output logic                     flush,
    output logic [XLEN-1:0]          redirect_pc,
    output logic                     stall_fetch,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     err_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0] pc_q [DEPTH];
    logic [DEPTH-1:0] pred_q;
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;

    logic full, pop, mis, push;
    logic [XLEN-1:0] head_pc;

    // p0: queue-head comparison against the resolved outcome
    assign full    = (count == FULL_CNT);
    assign head_pc = pc_q[rptr];
    assign pop     = ex_br_valid && (count != '0);
    assign mis     = pop && (pred_q[rptr] ^ ex_taken);
    // A full queue can still accept a push when the head leaves this cycle;
    // a mispredict makes any same-cycle fetch wrong-path, so it is dropped.
    assign push    = fetch_br_valid && (!full || pop) && !mis;

    assign stall_fetch = full;
    assign q_count     = count;

    // Entry storage carries no reset: validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wptr]   <= fetch_pc;
            pred_q[wptr] <= prediction;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (mis) begin
            count <= '0;
            rptr  <= wptr;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // p1: registered training pulse, flush and redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_en     <= 1'b0;
            mispredicted  <= 1'b0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            err_underflow <= 1'b0;
        end else begin
            update_en    <= pop;
            mispredicted <= mis;
            flush        <= mis;
            if (mis)
                redirect_pc <= ex_taken ? ex_target : head_pc + XLEN'(4);
            if (ex_br_valid && (count == '0))
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with hand-computed expected values.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_br_valid;
    logic [31:0] fetch_pc;
    logic        prediction;
    logic        ex_br_valid;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        update_en;
    logic        mispredicted;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        stall_fetch;
    logic [2:0]  q_count;
    logic        err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolver #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_br_valid(fetch_br_valid), .fetch_pc(fetch_pc), .prediction(prediction),
        .ex_br_valid(ex_br_valid), .ex_taken(ex_taken), .ex_target(ex_target),
        .update_en(update_en), .mispredicted(mispredicted), .flush(flush),
        .redirect_pc(redirect_pc), .stall_fetch(stall_fetch), .q_count(q_count),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic pr,
                         input logic ev, input logic tk, input logic [31:0] tg);
        fetch_br_valid = fv; fetch_pc = pc; prediction = pr;
        ex_br_valid = ev; ex_taken = tk; ex_target = tg;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_update_en", {31'd0, update_en}, 0);
        chk("rst_q_count", {29'd0, q_count}, 0);
        step(); step();
        #2 rst_n = 1'b1;
        step();
        chk("init_flush", {31'd0, flush}, 0);
        chk("init_mispred", {31'd0, mispredicted}, 0);
        chk("init_redirect", redirect_pc, 0);
        chk("init_stall", {31'd0, stall_fetch}, 0);
        chk("init_err", {31'd0, err_underflow}, 0);

        // Predicted not-taken, actually taken
        drive(1, 32'h100, 0, 0, 0, 0); step();
        chk("t1_qcount_push", {29'd0, q_count}, 1);
        drive(0, 0, 0, 1, 1, 32'h200); step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_update_en", {31'd0, update_en}, 1);
        chk("t1_mispred", {31'd0, mispredicted}, 1);
        chk("t1_flush", {31'd0, flush}, 1);
        chk("t1_redirect", redirect_pc, 32'h200);
        chk("t1_qcount", {29'd0, q_count}, 0);
        step();
        chk("t1_update_drop", {31'd0, update_en}, 0);
        chk("t1_flush_drop", {31'd0, flush}, 0);

        // Predicted taken, actually not taken: fall-through redirect
        drive(1, 32'h40, 1, 0, 0, 0); step();
        drive(0, 0, 0, 1, 0, 32'h999); step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_redirect", redirect_pc, 32'h44);
        chk("t2_flush", {31'd0, flush}, 1);
        chk("t2_mispred", {31'd0, mispredicted}, 1);
        drive(1, 32'h80, 1, 0, 0, 0); step();
        drive(0, 0, 0, 1, 1, 32'h300); step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_ok_update", {31'd0, update_en}, 1);
        chk("t2_ok_mispred", {31'd0, mispredicted}, 0);
        chk("t2_ok_flush", {31'd0, flush}, 0);
        chk("t2_redirect_hold", redirect_pc, 32'h44);

        // Fill to full with preds 1,0,1,0 so pop order shows in mispredicted
        drive(1, 32'h0, 1, 0, 0, 0); step();
        drive(1, 32'h4, 0, 0, 0, 0); step();
        drive(1, 32'h8, 1, 0, 0, 0); step();
        drive(1, 32'hC, 0, 0, 0, 0); step();
        chk("t3_qcount_full", {29'd0, q_count}, 4);
        chk("t3_stall", {31'd0, stall_fetch}, 1);
        drive(1, 32'h10, 0, 0, 0, 0); step();
        chk("t3_drop_qcount", {29'd0, q_count}, 4);
        chk("t3_drop_no_update", {31'd0, update_en}, 0);
        drive(1, 32'h20, 1, 1, 1, 32'h700); step();
        chk("t3_pp_qcount", {29'd0, q_count}, 4);
        chk("t3_pp_update", {31'd0, update_en}, 1);
        chk("t3_pp_mis_h0", {31'd0, mispredicted}, 0);
        drive(0, 0, 0, 1, 0, 0); step();
        chk("t3_mis_h4", {31'd0, mispredicted}, 0);
        chk("t3_stall_clear", {31'd0, stall_fetch}, 0);
        drive(0, 0, 0, 1, 1, 32'h700); step();
        chk("t3_mis_h8", {31'd0, mispredicted}, 0);
        drive(0, 0, 0, 1, 0, 0); step();
        chk("t3_mis_hC", {31'd0, mispredicted}, 0);
        chk("t3_qcount_1", {29'd0, q_count}, 1);
        drive(0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_last_mis", {31'd0, mispredicted}, 1);
        chk("t3_last_redirect", redirect_pc, 32'h24);
        chk("t3_qcount_0", {29'd0, q_count}, 0);

        // Mispredict flushes queue and drops same-cycle push; then underflow
        drive(1, 32'h50, 0, 0, 0, 0); step();
        drive(1, 32'h54, 0, 0, 0, 0); step();
        drive(1, 32'h58, 0, 0, 0, 0); step();
        chk("t4_qcount_3", {29'd0, q_count}, 3);
        drive(1, 32'h5C, 0, 1, 1, 32'h500); step();
        chk("t4_qcount_flushed", {29'd0, q_count}, 0);
        chk("t4_flush", {31'd0, flush}, 1);
        chk("t4_redirect", redirect_pc, 32'h500);
        drive(0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_uf_no_update", {31'd0, update_en}, 0);
        chk("t4_uf_err", {31'd0, err_underflow}, 1);
        chk("t4_uf_no_flush", {31'd0, flush}, 0);
        step();
        chk("t4_err_sticky", {31'd0, err_underflow}, 1);

        // Pointer wrap with push/correct-resolve pairs
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h1000 + 32'(4 * i), i[0], 0, 0, 0); step();
            chk("t5_qcount_push", {29'd0, q_count}, 1);
            drive(0, 0, 0, 1, i[0], 32'h2000); step();
            chk("t5_update", {31'd0, update_en}, 1);
            chk("t5_mispred", {31'd0, mispredicted}, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_qcount_end", {29'd0, q_count}, 0);

        // Reset mid-operation with a pulse visible and a resolve pending
        drive(1, 32'h60, 1, 0, 0, 0); step();
        drive(1, 32'h64, 1, 0, 0, 0); step();
        drive(1, 32'h68, 1, 0, 0, 0); step();
        drive(0, 0, 0, 1, 1, 32'h800); step();
        chk("t6_pre_update", {31'd0, update_en}, 1);
        chk("t6_pre_qcount", {29'd0, q_count}, 2);
        drive(0, 0, 0, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_update", {31'd0, update_en}, 0);
        chk("t6_rst_mispred", {31'd0, mispredicted}, 0);
        chk("t6_rst_flush", {31'd0, flush}, 0);
        chk("t6_rst_redirect", redirect_pc, 0);
        chk("t6_rst_err", {31'd0, err_underflow}, 0);
        chk("t6_rst_qcount", {29'd0, q_count}, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        step();
        chk("t6_post_qcount", {29'd0, q_count}, 0);
        chk("t6_post_update", {31'd0, update_en}, 0);
        chk("t6_post_stall", {31'd0, stall_fetch}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
